// File: rtl/ac97_frame_decoder.sv
// ============================================================================
// Module   : ac97_frame_decoder
// Purpose  : Codec-side AC97 output-link deserializer. Recovers slot 0 (tag),
//            slots 1/2 (command) and slots 3/4 (PCM) from the Sync/SData_Out
//            stream. Optional statistics counters: AC97_DEC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ac97_frame_decoder #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_en,
  input  logic                    sync,
  input  logic                    sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic [19:0]             cmd_addr,
  output logic [19:0]             cmd_data,
  output logic                    cmd_valid,
  output logic [15:0]             tag,
  output logic                    sync_error,
  output logic [15:0]             frame_count,
  output logic [15:0]             error_count
);

  localparam logic [0:0] S_HUNT  = 1'b0;
  localparam logic [0:0] S_FRAME = 1'b1;

  localparam logic [8:0] c_SYNC_LEN   = 9'(SYNC_LEN);
  localparam logic [7:0] c_SLOT0_END  = 8'd15;
  localparam logic [7:0] c_SLOT1_END  = 8'd35;
  localparam logic [7:0] c_SLOT2_END  = 8'd55;
  localparam logic [7:0] c_SLOT3_END  = 8'd75;
  localparam logic [7:0] c_SLOT4_END  = 8'd95;
  localparam logic [7:0] c_LAST_BIT   = 8'd255;

  logic [0:0]              r_state;
  logic [0:0]              w_state_next;
  logic [7:0]              r_bit_cnt;
  logic [18:0]             r_shift;
  logic                    r_sync_prev;

  logic [15:0]             r_tag_stage;
  logic [19:0]             r_addr_stage;
  logic [19:0]             r_data_stage;
  logic [SAMPLE_WIDTH-1:0] r_left_stage;
  logic [SAMPLE_WIDTH-1:0] r_right_stage;

  logic [SAMPLE_WIDTH-1:0] r_sample_left;
  logic [SAMPLE_WIDTH-1:0] r_sample_right;
  logic                    r_sample_valid;
  logic [19:0]             r_cmd_addr;
  logic [19:0]             r_cmd_data;
  logic                    r_cmd_valid;
  logic [15:0]             r_tag;
  logic                    r_sync_error;

  logic [19:0]             w_shift_next;
  logic                    w_rise;
  logic                    w_exp_sync;
  logic                    w_start;
  logic                    w_viol;
  logic                    w_restart;
  logic                    w_advance;
  logic                    w_commit;

  assign w_shift_next = {r_shift, sdata};
  assign w_rise       = sync & ~r_sync_prev;
  assign w_exp_sync   = ({1'b0, r_bit_cnt} < c_SYNC_LEN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HUNT: begin
        if (bit_en && w_rise) begin
          w_state_next = S_FRAME;
        end
      end
      S_FRAME: begin
        if (bit_en && (sync != w_exp_sync) && !w_rise) begin
          w_state_next = S_HUNT;
        end
      end
      default: w_state_next = S_HUNT;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_start   = 1'b0;
    w_viol    = 1'b0;
    w_restart = 1'b0;
    w_advance = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      S_HUNT: begin
        w_start = bit_en & w_rise;
      end
      S_FRAME: begin
        w_viol    = bit_en & (sync != w_exp_sync);
        w_restart = w_viol & w_rise;
        w_advance = bit_en & ~w_viol;
        w_commit  = w_advance & (r_bit_cnt == c_LAST_BIT);
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_sync_prev    <= 1'b0;
      r_tag_stage    <= '0;
      r_addr_stage   <= '0;
      r_data_stage   <= '0;
      r_left_stage   <= '0;
      r_right_stage  <= '0;
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_sample_valid <= 1'b0;
      r_cmd_addr     <= '0;
      r_cmd_data     <= '0;
      r_cmd_valid    <= 1'b0;
      r_tag          <= '0;
      r_sync_error   <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_sync_error   <= w_viol;

      if (bit_en) begin
        r_sync_prev <= sync;
      end

      // A rising edge during a frame re-anchors bit 0 on that same bit
      if (w_start || w_restart) begin
        r_bit_cnt <= 8'd1;
        r_shift   <= w_shift_next[18:0];
      end else if (w_advance) begin
        r_bit_cnt <= r_bit_cnt + 8'd1;
        r_shift   <= w_shift_next[18:0];
        case (r_bit_cnt)
          c_SLOT0_END: r_tag_stage   <= w_shift_next[15:0];
          c_SLOT1_END: r_addr_stage  <= w_shift_next;
          c_SLOT2_END: r_data_stage  <= w_shift_next;
          c_SLOT3_END: r_left_stage  <= w_shift_next[19 -: SAMPLE_WIDTH];
          c_SLOT4_END: r_right_stage <= w_shift_next[19 -: SAMPLE_WIDTH];
          default: ;
        endcase
      end

      if (w_commit) begin
        r_tag <= r_tag_stage;
        if (r_tag_stage[15]) begin
          if (r_tag_stage[14] && r_tag_stage[13]) begin
            r_cmd_addr  <= r_addr_stage;
            r_cmd_data  <= r_data_stage;
            r_cmd_valid <= 1'b1;
          end
          if (r_tag_stage[12]) begin
            r_sample_left <= r_left_stage;
          end
          if (r_tag_stage[11]) begin
            r_sample_right <= r_right_stage;
          end
          r_sample_valid <= r_tag_stage[12] | r_tag_stage[11];
        end
      end
    end
  end

  assign sample_left  = r_sample_left;
  assign sample_right = r_sample_right;
  assign sample_valid = r_sample_valid;
  assign cmd_addr     = r_cmd_addr;
  assign cmd_data     = r_cmd_data;
  assign cmd_valid    = r_cmd_valid;
  assign tag          = r_tag;
  assign sync_error   = r_sync_error;

`ifdef AC97_DEC_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_error_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= '0;
      r_error_count <= '0;
    end else begin
      if (w_commit && (r_frame_count != 16'hFFFF)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_viol && (r_error_count != 16'hFFFF)) begin
        r_error_count <= r_error_count + 16'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
`else
  assign frame_count = 16'h0000;
  assign error_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ac97_frame_decoder.sv
// ============================================================================
// Module   : tb_ac97_frame_decoder
// Purpose  : Directed self-checking bench for ac97_frame_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ac97_frame_decoder;

  logic        clk;
  logic        reset;
  logic        bit_en;
  logic        sync;
  logic        sdata;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic [19:0] cmd_addr;
  logic [19:0] cmd_data;
  logic        cmd_valid;
  logic [15:0] tag;
  logic        sync_error;
  logic [15:0] frame_count;
  logic [15:0] error_count;

  int n_total = 0;
  int n_bad   = 0;
  int n_sv    = 0;
  int n_cv    = 0;
  int n_err   = 0;

  ac97_frame_decoder #(
    .SAMPLE_WIDTH (16),
    .SYNC_LEN     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_en       (bit_en),
    .sync         (sync),
    .sdata        (sdata),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .tag          (tag),
    .sync_error   (sync_error),
    .frame_count  (frame_count),
    .error_count  (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle; a stuck strobe inflates the count
  always @(negedge clk) begin
    if (sample_valid) n_sv++;
    if (cmd_valid)    n_cv++;
    if (sync_error)   n_err++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick(input logic b, input logic s, input logic d);
    @(negedge clk);
    bit_en = b;
    sync   = s;
    sdata  = d;
  endtask

  task automatic send_bit(input logic s, input logic d);
    tick(1'b1, s, d);
    repeat (3) tick(1'b0, s, d);
  endtask

  function automatic logic [255:0] mk(input logic [15:0] t, input logic [19:0] s1,
                                      input logic [19:0] s2, input logic [19:0] s3,
                                      input logic [19:0] s4);
    mk = {t, s1, s2, s3, s4, 160'h0};
  endfunction

  task automatic send_frame(input logic [255:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit(i < 16, fr[255-i]);
    end
  endtask

  task automatic check_stats(input string name, input logic [15:0] fc, input logic [15:0] ec);
`ifdef AC97_DEC_STATS_EN
    chk({name, "_frame_count"}, {16'h0, frame_count}, {16'h0, fc});
    chk({name, "_error_count"}, {16'h0, error_count}, {16'h0, ec});
`else
    chk({name, "_frame_count"}, {16'h0, frame_count}, 32'h0);
    chk({name, "_error_count"}, {16'h0, error_count}, 32'h0);
`endif
  endtask

  initial begin
    reset  = 1'b1;
    bit_en = 1'b0;
    sync   = 1'b0;
    sdata  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left",  {16'h0, sample_left},  32'h0);
    chk("rst_right", {16'h0, sample_right}, 32'h0);
    chk("rst_addr",  {12'h0, cmd_addr},     32'h0);
    chk("rst_data",  {12'h0, cmd_data},     32'h0);
    chk("rst_tag",   {16'h0, tag},          32'h0);
    chk("rst_strobes", {29'h0, sample_valid, cmd_valid, sync_error}, 32'h0);
    check_stats("rst", 16'd0, 16'd0);
    reset = 1'b0;
    repeat (3) send_bit(1'b0, 1'b0);

    // Valid playback frame
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h12340, 20'hABCD0), 256);
    chk("a_left",  {16'h0, sample_left},  32'h1234);
    chk("a_right", {16'h0, sample_right}, 32'hABCD);
    chk("a_tag",   {16'h0, tag},          32'h9800);
    chk("a_sv",    n_sv,  32'd1);
    chk("a_cv",    n_cv,  32'd0);
    chk("a_err",   n_err, 32'd0);

    // Invalid-tag frame
    send_frame(mk(16'h1800, 20'h0, 20'h0, 20'h55550, 20'h0), 256);
    chk("b_left", {16'h0, sample_left}, 32'h1234);
    chk("b_tag",  {16'h0, tag},         32'h1800);
    chk("b_sv",   n_sv, 32'd1);

    // Command frame
    send_frame(mk(16'hE000, 20'h02000, 20'h80800, 20'h0, 20'h0), 256);
    chk("c_addr", {12'h0, cmd_addr}, 32'h02000);
    chk("c_data", {12'h0, cmd_data}, 32'h80800);
    chk("c_cv",   n_cv, 32'd1);
    chk("c_sv",   n_sv, 32'd1);
    chk("c_tag",  {16'h0, tag}, 32'hE000);

    // Early sync at bit 100 restarts on that edge
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'hFFFF0, 20'hEEEE0), 100);
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h5A5A0, 20'h0F0F0), 256);
    chk("e_err",   n_err, 32'd1);
    chk("e_sv",    n_sv,  32'd2);
    chk("e_left",  {16'h0, sample_left},  32'h5A5A);
    chk("e_right", {16'h0, sample_right}, 32'h0F0F);

    // Sync drops at bit 8, then hunt and decode a left-only frame
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h11110, 20'h22220), 8);
    repeat (4) send_bit(1'b0, 1'b1);
    chk("f_err", n_err, 32'd2);
    send_frame(mk(16'h9000, 20'h0, 20'h0, 20'h76540, 20'h99990), 256);
    chk("g_left",  {16'h0, sample_left},  32'h7654);
    chk("g_right", {16'h0, sample_right}, 32'h0F0F);
    chk("g_tag",   {16'h0, tag},          32'h9000);
    chk("g_err",   n_err, 32'd2);
    check_stats("g", 16'd5, 16'd2);

    // Reset at bit 60 discards the partial frame
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'hAAAA0, 20'hBBBB0), 60);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("r_left",  {16'h0, sample_left},  32'h0);
    chk("r_right", {16'h0, sample_right}, 32'h0);
    chk("r_tag",   {16'h0, tag},          32'h0);
    chk("r_addr",  {12'h0, cmd_addr},     32'h0);
    check_stats("r", 16'd0, 16'd0);
    reset = 1'b0;
    repeat (2) send_bit(1'b0, 1'b0);
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h11110, 20'h22220), 256);
    chk("i_left", {16'h0, sample_left}, 32'h1111);
    send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h33330, 20'h44440), 256);
    chk("j_left",  {16'h0, sample_left},  32'h3333);
    chk("j_right", {16'h0, sample_right}, 32'h4444);
    chk("j_sv",    n_sv,  32'd5);
    chk("j_err",   n_err, 32'd2);
    check_stats("j", 16'd2, 16'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
